seq_detector_param: RTL and testbench

//  Parametrised serial pattern detector: next generation of the fixed-pattern Moore detectors.

---
 rtl/seq_detector_param.sv | 144 ++++++++++++++
 tb/tb_seq_detector_param.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//   Parametrised serial pattern detector. One bit is shifted in on every clock
//   edge where x_valid is high. The newest N bits are compared with a
//   pattern register that can be reloaded at run time. A match gives a
//   registered one-cycle pulse on y and increments a saturating counter.
//   OVERLAP selects whether the bits of a match can also count towards the
//   next match.
//
//   Optional feature: define SEQ_DET_MASK_EN to add the pat_mask port and a
//   mask register. A mask bit of 1 marks that pattern bit as don't-care.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   x           in   serial data bit
//   x_valid     in   1 = sample x on this edge, 0 = hold the history
//   pat_load    in   load pat_in (and pat_mask) and restart the stream
//   pat_in      in   N-bit pattern, MSB = oldest bit
//   pat_mask    in   N-bit don't-care mask (SEQ_DET_MASK_EN only)
//   cnt_clr     in   synchronous clear of match_count
//   y           out  registered match pulse
//   fill        out  number of valid history bits, 0..N
//   match_count out  saturating match counter
// -----------------------------------------------------------------------------
module seq_detector_param #(
   parameter int          N       = 4,
   parameter logic [N-1:0] PATTERN = 4'b1101,
   parameter bit          OVERLAP = 1'b1,
   parameter int          CNT_W   = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       x,
   input  logic                       x_valid,
   input  logic                       pat_load,
   input  logic [N-1:0]               pat_in,
`ifdef SEQ_DET_MASK_EN
   input  logic [N-1:0]               pat_mask,
`endif
   input  logic                       cnt_clr,
   output logic                       y,
   output logic [$clog2(N+1)-1:0]     fill,
   output logic [CNT_W-1:0]           match_count
);

   localparam int FW = $clog2(N+1);
   localparam logic [FW-1:0]    FILL_MAX = FW'(N);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   // Only the newest N-1 bits are stored. The oldest bit of an N-bit window
   // is dropped when the next bit arrives, so it is never needed again.
   logic [N-2:0]     hist_q, hist_d;
   logic [FW-1:0]    fill_q, fill_d;
   logic             y_q, y_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     pat_q, pat_d;
`ifdef SEQ_DET_MASK_EN
   logic [N-1:0]     mask_q, mask_d;
`endif

   logic [N-1:0]  nh;
   logic [FW-1:0] nf;
   logic          cmp_ok;
   logic          hit;

   // NOTE: every signal assigned in always_comb gets a default value first.
   // Without it, a path that does not assign the signal infers a latch.
   always_comb begin
      nh = {hist_q, x};
      nf = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
`ifdef SEQ_DET_MASK_EN
      cmp_ok = (((nh ^ pat_q) & ~mask_q) == '0);
`else
      cmp_ok = (nh == pat_q);
`endif
      // A load on the same edge discards x, so it cannot cause a hit.
      // A window that is not yet full cannot match.
      hit = x_valid && !pat_load && (nf == FILL_MAX) && cmp_ok;

      hist_d = hist_q;
      fill_d = fill_q;
      y_d    = 1'b0;
      pat_d  = pat_q;
`ifdef SEQ_DET_MASK_EN
      mask_d = mask_q;
`endif

      if (pat_load) begin
         pat_d  = pat_in;
`ifdef SEQ_DET_MASK_EN
         mask_d = pat_mask;
`endif
         hist_d = '0;
         fill_d = '0;
      end else if (x_valid) begin
         hist_d = nh[N-2:0];
         fill_d = nf;
         y_d    = hit;
         if (!OVERLAP && hit) begin
            hist_d = '0;
            fill_d = '0;
         end
      end

      // Clear wins over a hit on the same edge.
      cnt_d = cnt_q;
      if (cnt_clr)
         cnt_d = '0;
      else if (hit && (cnt_q != CNT_MAX))
         cnt_d = cnt_q + CNT_W'(1);
   end

   // NOTE: all registers, including the pattern register, get a reset value.
   // This makes a reset in the middle of a stream start from a known state.
   // NOTE: sequential state uses non-blocking assignments only, so all
   // registers update together at the clock edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist_q <= '0;
         fill_q <= '0;
         y_q    <= 1'b0;
         cnt_q  <= '0;
         pat_q  <= PATTERN;
`ifdef SEQ_DET_MASK_EN
         mask_q <= '0;
`endif
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
         y_q    <= y_d;
         cnt_q  <= cnt_d;
         pat_q  <= pat_d;
`ifdef SEQ_DET_MASK_EN
         mask_q <= mask_d;
`endif
      end
   end

   assign y           = y_q;
   assign fill        = fill_q;
   assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
//   Directed bench for seq_detector_param. Three instances share one stimulus:
//     u_a : N=4, PATTERN=1101, OVERLAP=1, CNT_W=8
//     u_b : N=4, PATTERN=1101, OVERLAP=0, CNT_W=8
//     u_c : N=4, PATTERN=1101, OVERLAP=1, CNT_W=2
//   The SEQ_DET_MASK_EN build also exercises the don't-care mask.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       x = 1'b0;
   logic       x_valid = 1'b0;
   logic       pat_load = 1'b0;
   logic       cnt_clr = 1'b0;
   logic [3:0] pat_in = 4'b0000;
`ifdef SEQ_DET_MASK_EN
   logic [3:0] pat_mask = 4'b0000;
`endif

   logic       ya, yb, yc;
   logic [2:0] fa, fb, fc;
   logic [7:0] ca, cb;
   logic [1:0] cc;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seq_detector_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) u_a (
      .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pat_load(pat_load),
      .pat_in(pat_in),
`ifdef SEQ_DET_MASK_EN
      .pat_mask(pat_mask),
`endif
      .cnt_clr(cnt_clr), .y(ya), .fill(fa), .match_count(ca));

   seq_detector_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) u_b (
      .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pat_load(pat_load),
      .pat_in(pat_in),
`ifdef SEQ_DET_MASK_EN
      .pat_mask(pat_mask),
`endif
      .cnt_clr(cnt_clr), .y(yb), .fill(fb), .match_count(cb));

   seq_detector_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(2)) u_c (
      .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pat_load(pat_load),
      .pat_in(pat_in),
`ifdef SEQ_DET_MASK_EN
      .pat_mask(pat_mask),
`endif
      .cnt_clr(cnt_clr), .y(yc), .fill(fc), .match_count(cc));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge with the given inputs. Outputs are sampled 1 time unit later.
   task automatic step(input logic v, input logic b, input logic clr);
      x_valid = v;
      x       = b;
      cnt_clr = clr;
      @(posedge clk);
      #1;
      x_valid = 1'b0;
      cnt_clr = 1'b0;
   endtask

   // Pattern load with a valid bit on the same edge. That bit must be discarded.
   task automatic load(input logic [3:0] p, input logic [3:0] m);
      pat_load = 1'b1;
      pat_in   = p;
`ifdef SEQ_DET_MASK_EN
      pat_mask = m;
`endif
      x_valid  = 1'b1;
      x        = 1'b1;
      @(posedge clk);
      #1;
      pat_load = 1'b0;
      x_valid  = 1'b0;
      if (m != 4'b0000) begin end
   endtask

   task automatic do_reset;
      reset = 1'b0;
      #2;
      check("rst_y",    {31'd0, ya}, 32'd0);
      check("rst_fill", {29'd0, fa}, 32'd0);
      check("rst_cnt",  {24'd0, ca}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   logic [6:0]  s1;
   logic [6:0]  e1a;
   logic [6:0]  e1b;
   logic [3:0]  s3;
   logic [3:0]  s4;
   logic [15:0] s5;

   initial begin
      // ---------------- reset state
      @(posedge clk);
      #1;
      check("init_y_a",    {31'd0, ya}, 32'd0);
      check("init_y_b",    {31'd0, yb}, 32'd0);
      check("init_fill_a", {29'd0, fa}, 32'd0);
      check("init_cnt_a",  {24'd0, ca}, 32'd0);
      check("init_cnt_c",  {30'd0, cc}, 32'd0);
      reset = 1'b1;

      // ---------------- stream 1,1,0,1,1,0,1: overlapping vs flushing
      s1  = 7'b1101101;
      e1a = 7'b0001001;
      e1b = 7'b0001000;
      for (int i = 6; i >= 0; i--) begin
         step(1'b1, s1[i], 1'b0);
         check($sformatf("t1_y_a_bit%0d", 7 - i), {31'd0, ya}, {31'd0, e1a[i]});
         check($sformatf("t1_y_b_bit%0d", 7 - i), {31'd0, yb}, {31'd0, e1b[i]});
      end
      check("t1_cnt_a",  {24'd0, ca}, 32'd2);
      check("t1_fill_a", {29'd0, fa}, 32'd4);
      check("t2_cnt_b",  {24'd0, cb}, 32'd1);
      check("t2_fill_b", {29'd0, fb}, 32'd3);
      step(1'b0, 1'b0, 1'b0);
      check("t1_y_a_idle", {31'd0, ya}, 32'd0);

      // ---------------- x_valid gaps inside 1,1,0,1
      do_reset();
      s3 = 4'b1101;
      for (int i = 3; i >= 0; i--) begin
         step(1'b1, s3[i], 1'b0);
         check($sformatf("t3_y_bit%0d", 4 - i), {31'd0, ya}, {31'd0, (i == 0)});
         if (i > 0) begin
            for (int g = 0; g < 3; g++) begin
               step(1'b0, 1'b1, 1'b0);
               check($sformatf("t3_y_gap%0d_%0d", 4 - i, g), {31'd0, ya}, 32'd0);
            end
            check($sformatf("t3_fill_gap%0d", 4 - i), {29'd0, fa}, 32'(4 - i));
         end
      end
      check("t3_cnt_a", {24'd0, ca}, 32'd1);
      step(1'b0, 1'b0, 1'b0);
      check("t3_y_after", {31'd0, ya}, 32'd0);

      // ---------------- pattern load with a coincident valid bit
      do_reset();
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      check("t4_fill_pre", {29'd0, fa}, 32'd2);
      load(4'b0110, 4'b0000);
      check("t4_fill_load", {29'd0, fa}, 32'd0);
      check("t4_y_load",    {31'd0, ya}, 32'd0);
      s4 = 4'b0110;
      for (int i = 3; i >= 0; i--) begin
         step(1'b1, s4[i], 1'b0);
         check($sformatf("t4_y_bit%0d", 4 - i), {31'd0, ya}, {31'd0, (i == 0)});
      end
      check("t4_cnt_a", {24'd0, ca}, 32'd1);

      // ---------------- saturation on CNT_W=2, clear versus hit
      do_reset();
      s5 = 16'b1101101101101101;
      for (int i = 15; i >= 0; i--) begin
         step(1'b1, s5[i], 1'b0);
         check($sformatf("t5_y_bit%0d", 16 - i), {31'd0, yc},
               {31'd0, ((15 - i) >= 3) && (((15 - i) % 3) == 0)});
      end
      check("t5_cnt_c_sat", {30'd0, cc}, 32'd3);
      check("t5_cnt_a",     {24'd0, ca}, 32'd5);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      check("t5_y_clr",     {31'd0, ya}, 32'd1);
      check("t5_cnt_a_clr", {24'd0, ca}, 32'd0);
      check("t5_cnt_c_clr", {30'd0, cc}, 32'd0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      check("t5_cnt_a_resume", {24'd0, ca}, 32'd1);
      check("t5_cnt_c_resume", {30'd0, cc}, 32'd1);

      // ---------------- reset mid-stream restores the pattern and history
      load(4'b0110, 4'b0000);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      check("t6_fill_pre", {29'd0, fa}, 32'd3);
      do_reset();
      step(1'b1, 1'b1, 1'b0);
      check("t6_y_first",    {31'd0, ya}, 32'd0);
      check("t6_fill_first", {29'd0, fa}, 32'd1);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      check("t6_y_match", {31'd0, ya}, 32'd1);
      check("t6_fill",    {29'd0, fa}, 32'd4);

`ifdef SEQ_DET_MASK_EN
      // ---------------- don't-care mask 0010 with pattern 1101
      do_reset();
      load(4'b1101, 4'b0010);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 1'b0);
         check($sformatf("tm_y_bit%0d", i + 1), {31'd0, ya}, {31'd0, (i == 3)});
      end
      check("tm_cnt_a", {24'd0, ca}, 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Bounded runtime guard
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
